// File: rtl/fetch_ctrl_pkg.sv
// Shared types and PC-mux select encodings for the fetch sequencing controller
// and the PC datapath it drives.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StStall,
    StRedir
  } state_e;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_ALU    = 2'b10;
  localparam logic [1:0] PCSRC_HELD   = 2'b11;

  // JALR wins when both redirect flavours resolve in the same cycle.
  function automatic logic [1:0] redir_src(input logic jalr);
    return jalr ? PCSRC_ALU : PCSRC_TARGET;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller (master) and the PC datapath,
// decode stage and instruction memory (slave).
interface fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             stall_i;
  logic             branch_taken_i;
  logic             jalr_i;
  logic [WIDTH-1:0] target_i;
  logic             imem_ready_i;
  logic             imem_req_o;
  logic             pc_en_o;
  logic [1:0]       pc_src_o;
  logic [WIDTH-1:0] held_tgt_o;
  logic             instr_valid_o;
  logic             flush_o;
  logic [CNT_W-1:0] squash_cnt_o;

  modport master (
    input  stall_i, branch_taken_i, jalr_i, target_i, imem_ready_i,
    output imem_req_o, pc_en_o, pc_src_o, held_tgt_o, instr_valid_o, flush_o, squash_cnt_o
  );

  modport slave (
    output stall_i, branch_taken_i, jalr_i, target_i, imem_ready_i,
    input  imem_req_o, pc_en_o, pc_src_o, held_tgt_o, instr_valid_o, flush_o, squash_cnt_o
  );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: decides PC advance and mux source each cycle,
// handshakes with imem, honours stalls and defers redirects behind an outstanding fetch.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);
  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_held;
  logic             w_redir, w_held_load, w_sq_inc;
  logic             w_req, w_en, w_valid, w_flush;
  logic [1:0]       w_src;

  assign w_redir = bus.branch_taken_i | bus.jalr_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StBoot:  w_state_next = StFetch;
      StFetch: begin
        if (w_redir && !bus.imem_ready_i) begin
          w_state_next = StRedir;
        end else if (!w_redir && bus.imem_ready_i && bus.stall_i) begin
          w_state_next = StStall;
        end
      end
      StStall: if (w_redir || !bus.stall_i) w_state_next = StFetch;
      StRedir: if (bus.imem_ready_i) w_state_next = StFetch;
      default: w_state_next = StBoot;
    endcase
  end

  always_comb begin
    w_req       = 1'b0;
    w_en        = 1'b0;
    w_src       = PCSRC_PLUS4;
    w_valid     = 1'b0;
    w_flush     = 1'b0;
    w_held_load = 1'b0;
    w_sq_inc    = 1'b0;
    unique case (r_state)
      StBoot: ;
      StFetch: begin
        w_req = 1'b1;
        if (w_redir) begin
          w_flush = 1'b1;
          if (bus.imem_ready_i) begin
            w_en     = 1'b1;
            w_src    = redir_src(bus.jalr_i);
            w_sq_inc = 1'b1;
          end else begin
            w_held_load = 1'b1;
          end
        end else if (bus.imem_ready_i && !bus.stall_i) begin
          w_en    = 1'b1;
          w_valid = 1'b1;
        end
      end
      StStall: begin
        // Nothing is outstanding here, so a redirect squashes no fetch.
        if (w_redir) begin
          w_en    = 1'b1;
          w_src   = redir_src(bus.jalr_i);
          w_flush = 1'b1;
        end
      end
      StRedir: begin
        w_req = 1'b1;
        if (bus.imem_ready_i) begin
          w_en     = 1'b1;
          w_sq_inc = 1'b1;
          if (w_redir) begin
            w_src   = redir_src(bus.jalr_i);
            w_flush = 1'b1;
          end else begin
            w_src = PCSRC_HELD;
          end
        end else if (w_redir) begin
          w_held_load = 1'b1;
          w_flush     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held <= '0;
    end else if (w_held_load) begin
      r_held <= bus.target_i;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_squash_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_inc(w_sq_inc),
    .o_cnt(bus.squash_cnt_o)
  );

  assign bus.imem_req_o    = w_req;
  assign bus.pc_en_o       = w_en;
  assign bus.pc_src_o      = w_src;
  assign bus.instr_valid_o = w_valid;
  assign bus.flush_o       = w_flush;
  assign bus.held_tgt_o    = r_held;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_ctrl;
  typedef struct packed {
    logic        req;
    logic        en;
    logic [1:0]  src;
    logic        valid;
    logic        flush;
    logic [31:0] held;
    logic [15:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  obs_t  exp_q[$];
  string name_q[$];

  fetch_ctrl_if #(.WIDTH(32), .CNT_W(16)) bus ();

  fetch_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{req: bus.imem_req_o, en: bus.pc_en_o, src: bus.pc_src_o,
             valid: bus.instr_valid_o, flush: bus.flush_o, held: bus.held_tgt_o,
             cnt: bus.squash_cnt_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got req=%b en=%b src=%b valid=%b flush=%b held=%h cnt=%h, want req=%b en=%b src=%b valid=%b flush=%b held=%h cnt=%h",
                 nm, a.req, a.en, a.src, a.valid, a.flush, a.held, a.cnt,
                 e.req, e.en, e.src, e.valid, e.flush, e.held, e.cnt);
      end
    end
  end

  task automatic drive(input logic st, input logic br, input logic jr,
                       input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    bus.stall_i        = st;
    bus.branch_taken_i = br;
    bus.jalr_i         = jr;
    bus.target_i       = tgt;
    bus.imem_ready_i   = rdy;
  endtask

  task automatic expect_o(input string nm, input logic req, input logic en,
                          input logic [1:0] src, input logic valid, input logic flush,
                          input logic [31:0] held, input logic [15:0] cnt);
    obs_t e;
    e = '{req: req, en: en, src: src, valid: valid, flush: flush, held: held, cnt: cnt};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    bus.stall_i        = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.jalr_i         = 1'b0;
    bus.target_i       = '0;
    bus.imem_ready_i   = 1'b1;

    drive(0, 0, 0, 32'h0, 1);
    expect_o("reset", 0, 0, 2'b00, 0, 0, 32'h0, 16'h0);
    drive(0, 0, 0, 32'h0, 1);
    rst = 1'b1;
    expect_o("boot", 0, 0, 2'b00, 0, 0, 32'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, 1);
      expect_o("seq_plus4", 1, 1, 2'b00, 1, 0, 32'h0, 16'h0);
    end

    drive(0, 1, 0, 32'h100, 1);
    expect_o("branch_ready", 1, 1, 2'b01, 0, 1, 32'h0, 16'h0);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("after_branch", 1, 1, 2'b00, 1, 0, 32'h0, 16'h1);
    drive(0, 1, 1, 32'h80, 1);
    expect_o("jalr_wins", 1, 1, 2'b10, 0, 1, 32'h0, 16'h1);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("after_jalr", 1, 1, 2'b00, 1, 0, 32'h0, 16'h2);

    drive(0, 1, 0, 32'h200, 0);
    expect_o("redir_no_ready", 1, 0, 2'b00, 0, 1, 32'h0, 16'h2);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, 0);
      expect_o("redir_wait", 1, 0, 2'b00, 0, 0, 32'h200, 16'h2);
    end
    drive(0, 0, 0, 32'h0, 1);
    expect_o("redir_apply_held", 1, 1, 2'b11, 0, 0, 32'h200, 16'h2);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("after_held", 1, 1, 2'b00, 1, 0, 32'h200, 16'h3);

    drive(0, 0, 1, 32'h300, 0);
    expect_o("jalr_no_ready", 1, 0, 2'b00, 0, 1, 32'h200, 16'h3);
    drive(0, 1, 0, 32'h400, 0);
    expect_o("redir_overwrite", 1, 0, 2'b00, 0, 1, 32'h300, 16'h3);
    drive(0, 0, 1, 32'h500, 1);
    expect_o("redir_new_ready", 1, 1, 2'b10, 0, 1, 32'h400, 16'h3);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("after_new_redir", 1, 1, 2'b00, 1, 0, 32'h400, 16'h4);

    drive(1, 0, 0, 32'h0, 1);
    expect_o("stall_enter", 1, 0, 2'b00, 0, 0, 32'h400, 16'h4);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 32'h0, 1);
      expect_o("stall_hold", 0, 0, 2'b00, 0, 0, 32'h400, 16'h4);
    end
    drive(0, 0, 0, 32'h0, 1);
    expect_o("stall_release", 0, 0, 2'b00, 0, 0, 32'h400, 16'h4);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("refetch", 1, 1, 2'b00, 1, 0, 32'h400, 16'h4);
    drive(1, 0, 0, 32'h0, 1);
    expect_o("stall_enter2", 1, 0, 2'b00, 0, 0, 32'h400, 16'h4);
    drive(1, 1, 0, 32'h600, 1);
    expect_o("stall_redirect", 0, 1, 2'b01, 0, 1, 32'h400, 16'h4);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("after_stall_redir", 1, 1, 2'b00, 1, 0, 32'h400, 16'h4);
    drive(1, 0, 0, 32'h0, 0);
    expect_o("fetch_wait_stall", 1, 0, 2'b00, 0, 0, 32'h400, 16'h4);

    drive(0, 1, 0, 32'h700, 0);
    expect_o("redir_pre_reset", 1, 0, 2'b00, 0, 1, 32'h400, 16'h4);
    drive(0, 0, 0, 32'h0, 0);
    expect_o("redir_before_reset", 1, 0, 2'b00, 0, 0, 32'h700, 16'h4);
    drive(0, 0, 0, 32'h0, 0);
    rst = 1'b0;
    expect_o("async_reset", 0, 0, 2'b00, 0, 0, 32'h0, 16'h0);
    drive(0, 0, 0, 32'h0, 1);
    rst = 1'b1;
    expect_o("boot2", 0, 0, 2'b00, 0, 0, 32'h0, 16'h0);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("fetch_after_reset", 1, 1, 2'b00, 1, 0, 32'h0, 16'h0);

    // Back-to-back ready redirects squash every cycle; drive the counter to all-ones.
    for (int i = 0; i < 65535; i++) begin
      drive(0, 1, 0, 32'h100, 1);
    end
    drive(0, 1, 0, 32'h100, 1);
    expect_o("squash_at_max", 1, 1, 2'b01, 0, 1, 32'h0, 16'hFFFF);
    drive(0, 0, 0, 32'h0, 1);
    expect_o("squash_saturated", 1, 1, 2'b00, 1, 0, 32'h0, 16'hFFFF);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the PC datapath: PC register, PC+4/PC+Imm adders and the 4-input PC mux. Each cycle it decides whether the PC advances and which mux input is selected. It handshakes with instruction memory, honours decode stalls, and applies execute-stage redirects (branch/JAL via PC+Imm, JALR via ALU result). A redirect that arrives while a fetch is outstanding is held and applied through mux input 3 once that fetch completes.

## Interface
Parameters:
- WIDTH, 32, PC/target width
- CNT_W, 16, width of squash performance counter

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- stall_i  in  1  decode hazard stall; hold PC, do not consume fetched instruction
- branch_taken_i  in  1  execute resolved taken branch/JAL; target on mux input 1
- jalr_i  in  1  execute resolved JALR; target on mux input 2
- target_i  in  WIDTH  resolved redirect target value, valid with branch_taken_i/jalr_i
- imem_ready_i  in  1  instruction memory returns data for current request
- imem_req_o  out  1  fetch request at current PC
- pc_en_o  out  1  PC register load enable
- pc_src_o  out  2  PC mux select: 00 PC+4, 01 PC+Imm, 10 ALU result, 11 held target
- held_tgt_o  out  WIDTH  latched redirect target, feeds mux input 3
- instr_valid_o  out  1  fetched instruction accepted into IF/ID
- flush_o  out  1  squash IF/ID and ID/EX contents
- squash_cnt_o  out  CNT_W  saturating count of squashed fetches

## Operation
- Redirect = branch_taken_i | jalr_i. If both are high, JALR wins: src 10.
- Redirect overrides stall in every state except BOOT.
- States: BOOT, FETCH, STALL, REDIR. Outputs are Mealy: a function of state and inputs.
- BOOT:
  - All outputs 0. Inputs ignored.
  - Next state FETCH. Lasts exactly 1 cycle after reset release.
- FETCH:
  - imem_req_o=1.
  - Redirect & imem_ready_i: pc_en_o=1, pc_src_o=01/10, flush_o=1, instr_valid_o=0, squash_cnt++. Stay FETCH.
  - Redirect & !imem_ready_i: held_tgt_o<=target_i, flush_o=1, pc_en_o=0. Go to REDIR.
  - No redirect, ready, !stall: pc_en_o=1, pc_src_o=00, instr_valid_o=1.
  - No redirect, ready, stall: pc_en_o=0, instr_valid_o=0. Go to STALL.
  - No redirect, !ready: all outputs except imem_req_o are 0. Stall is ignored until ready.
- STALL:
  - imem_req_o=0, pc_en_o=0.
  - stall_i low: go to FETCH, which re-fetches the same PC.
  - Redirect: pc_en_o=1, pc_src_o=01/10, flush_o=1. Go to FETCH. No squash count, because nothing is outstanding.
- REDIR:
  - imem_req_o=1. The stale request stays up until ready; req never drops before ready once raised.
  - imem_ready_i & no new redirect: pc_en_o=1, pc_src_o=11, instr_valid_o=0, squash_cnt++. Go to FETCH.
  - imem_ready_i & new redirect: apply the new redirect with src 01/10. flush_o=1, squash_cnt++. Go to FETCH.
  - New redirect & !ready: overwrite held_tgt_o with target_i, flush_o=1. Stay REDIR.
- squash_cnt_o saturates at all-ones and never wraps.
- pc_src_o is 00 whenever pc_en_o=0.

## Timing
- Reset (rst=0, async):
  - State=BOOT.
  - held_tgt_o=0, squash_cnt_o=0.
  - All outputs 0 immediately, without waiting for a clock edge. This includes reset during REDIR: the outstanding request is abandoned.
- First imem_req_o: the 2nd rising edge after rst deasserts.
- Zero-wait memory (ready every cycle, no stall): PC advances by 4 every cycle.
- Redirect with ready: new PC loaded at the same clock edge. flush_o is asserted for one cycle.
- Redirect without ready: PC = held target at the edge ending the cycle in which ready arrives.
- held_tgt_o updates only on redirect cycles that do not load the PC.

## Structure
- Package fetch_ctrl_pkg:
  - State enum.
  - PC-source constants: PCSRC_PLUS4=2'b00, PCSRC_TARGET=2'b01, PCSRC_ALU=2'b10, PCSRC_HELD=2'b11. Shared with the PC mux top.
- Sub-module sat_counter (CNT_W, async active-low reset, inc input) implements squash_cnt_o.
- Everything else lives in fetch_ctrl: FSM plus held-target register.

## Test plan
- Reset then ready=1 every cycle, stall=0:
  - 1 BOOT cycle with all outputs 0.
  - Then pc_en_o=1, pc_src_o=00, instr_valid_o=1 every cycle.
  - squash_cnt_o=0.
- FETCH with ready=1, branch_taken_i=1, target_i=0x0000_0100: same cycle pc_en_o=1, pc_src_o=01, flush_o=1, instr_valid_o=0; squash_cnt_o=1 next cycle.
- jalr_i and branch_taken_i both high, target_i=0x80, ready=1: pc_src_o=10.
- Redirect target 0x0000_0200 with ready=0, then ready=0 for 3 more cycles, then ready=1:
  - Enter REDIR; imem_req_o stays 1.
  - held_tgt_o=0x200.
  - On the ready cycle: pc_src_o=11, pc_en_o=1, instr_valid_o=0.
- Stall: ready=1 & stall=1:
  - STALL with imem_req_o=0 and pc_en_o=0 while stall holds.
  - stall drops: FETCH, then pc_en_o=1 on next ready.
  - Redirect during STALL: immediate pc_src_o=01, flush_o=1.
- Async reset mid-REDIR: rst=0 between edges → imem_req_o=0, flush_o=0 immediately; held_tgt_o=0, squash_cnt_o=0. Force squash_cnt_o to 0xFFFF, squash again → stays 0xFFFF.
